// File: rtl/alu_bcd_display.sv
// alu_bcd_display: W-bit ALU on switch operands whose result is converted
// to decimal by an iterative double-dabble engine and shown on DIGITS
// active-low seven-segment digits, with registered {overflow, carry, zero}
// flags. Display and flags only change when a whole conversion completes.
module alu_bcd_display #(
    parameter int W      = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2*W+2:0]        io_sw,
    input  logic                  io_signed,
    output logic [2:0]            io_led,
    output logic [7*DIGITS-1:0]   io_seg,
    output logic                  io_busy
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;
    localparam int LW = W + 3;
    localparam logic [CW-1:0] LAST_CYC  = CW'(W - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;
    localparam logic [6:0]    SEG_MINUS = 7'b0111111;
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;
    localparam logic [7*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Active-low glyph for one decimal digit.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift in bit_in.
    function automatic logic [BW-1:0] bcd_step(input logic [BW-1:0] bcd, input logic bit_in);
        logic [BW-1:0] adj;
        logic [3:0]    nib;
        adj = {BW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end else begin
                nib = nib;
            end
            adj[4*i +: 4] = nib;
        end
        return {adj[BW-2:0], bit_in};
    endfunction

    // Place digits with leading-zero blanking and a minus above the top digit.
    function automatic logic [7*DIGITS-1:0] place(input logic [BW-1:0] bcd, input logic neg);
        logic [7*DIGITS-1:0] seg;
        int msd;
        msd = 0;
        seg = {(7*DIGITS){1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd = i;
            end else begin
                msd = msd;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= msd) begin
                seg[7*i +: 7] = glyph(bcd[4*i +: 4]);
            end else if (neg && (i == msd + 1)) begin
                seg[7*i +: 7] = SEG_MINUS;
            end else begin
                seg[7*i +: 7] = SEG_BLANK;
            end
        end
        return seg;
    endfunction

    logic [W-1:0]  a_s;
    logic [W-1:0]  b_s;
    logic [2:0]    op_s;
    logic [W:0]    sum_s;
    logic [W:0]    diff_s;
    logic          lt_s;
    logic [W-1:0]  r_s;
    logic          c_s;
    logic          v_s;
    logic [LW-1:0] cur_s;
    logic          neg_s;
    logic [BW-1:0] bcd_next_s;
    logic          zero_s;

    state_t              state_q, state_d;
    logic [LW-1:0]       last_q, last_d;
    logic [W-1:0]        mag_q, mag_d;
    logic                sign_q, sign_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [2:0]          led_q, led_d;
    logic                busy_q, busy_d;

    assign a_s    = io_sw[W-1:0];
    assign b_s    = io_sw[2*W-1:W];
    assign op_s   = io_sw[2*W+2:2*W];
    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    assign diff_s = {1'b0, a_s} + {1'b0, ~b_s} + {{W{1'b0}}, 1'b1};
    assign lt_s   = io_signed ? ($signed(a_s) < $signed(b_s)) : (a_s < b_s);

    // Combinational ALU producing result, carry and overflow.
    always_comb begin
        r_s = {W{1'b0}};
        c_s = 1'b0;
        v_s = 1'b0;
        case (op_s)
            3'b000: begin
                r_s = sum_s[W-1:0];
                c_s = sum_s[W];
                v_s = (a_s[W-1] == b_s[W-1]) && (sum_s[W-1] != a_s[W-1]);
            end
            3'b001: begin
                r_s = diff_s[W-1:0];
                c_s = diff_s[W];
                v_s = (a_s[W-1] != b_s[W-1]) && (diff_s[W-1] != a_s[W-1]);
            end
            3'b010:  r_s = ~a_s;
            3'b011:  r_s = a_s & b_s;
            3'b100:  r_s = a_s | b_s;
            3'b101:  r_s = a_s ^ b_s;
            3'b110:  r_s = {{(W-1){1'b0}}, lt_s};
            3'b111:  r_s = {{(W-1){1'b0}}, (a_s == b_s)};
            default: r_s = {W{1'b0}};
        endcase
    end

    assign cur_s      = {r_s, io_signed, c_s, v_s};
    assign neg_s      = io_signed & r_s[W-1];
    assign bcd_next_s = bcd_step(bcd_q, mag_q[W-1]);
    assign zero_s     = (last_q[LW-1:3] == {W{1'b0}});

    // Next-state logic: latch new inputs in IDLE, run W shift steps in CONV.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        led_d   = led_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (cur_s != last_q) begin
                    last_d  = cur_s;
                    // Two's-complement negate; the most negative value maps to 2^(W-1).
                    mag_d   = neg_s ? (~r_s + {{(W-1){1'b0}}, 1'b1}) : r_s;
                    sign_d  = neg_s;
                    bcd_d   = {BW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                bcd_d = bcd_next_s;
                mag_d = {mag_q[W-2:0], 1'b0};
                if (cnt_q == LAST_CYC) begin
                    // Commit the finished conversion together with its flags.
                    seg_d   = place(bcd_next_s, sign_q);
                    led_d   = {last_q[0], last_q[1], zero_s};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= {LW{1'b0}};
            mag_q  <= {W{1'b0}};
            sign_q <= 1'b0;
            bcd_q  <= {BW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            seg_q  <= SEG_RESET;
            led_q  <= 3'b000;
            busy_q <= 1'b0;
        end else begin
            last_q <= last_d;
            mag_q  <= mag_d;
            sign_q <= sign_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign io_seg  = seg_q;
    assign io_led  = led_q;
    assign io_busy = busy_q;

endmodule
